// File: rtl/sensor_avg_bank.sv
// Per-channel exponential averager bank with one shared update datapath and a low-level alarm.
// Latency: sample strobe to avg change is 1..NCH cycles (round-robin service slot); low_alarm lags avg by 1 cycle.
// Backpressure: none; a sample arriving while an older one still waits replaces it and sets the sticky ovr bit.
module sensor_avg_bank #(
   parameter int             NCH      = 4,
   parameter int             W        = 12,
   parameter int             AVG_SH   = 5,
   parameter int             ALARM_CH = 0,
   parameter logic [W-1:0]   LO_TH    = 12'hA98,
   parameter logic [W-1:0]   HYST     = 12'h010
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NCH-1:0]     smpl_vld,
   input  logic [NCH*W-1:0]   smpl_data,
   input  logic [NCH-1:0]     preload,
   input  logic               clr_ovr,
   output logic [NCH*W-1:0]   avg,
   output logic [NCH-1:0]     avg_vld,
   output logic [NCH-1:0]     ovr,
   output logic               low_alarm
);

   localparam int A  = W + AVG_SH;
   localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
   // Release threshold kept one bit wider so LO_TH+HYST can never wrap.
   localparam logic [W:0] REL_TH = {1'b0, LO_TH} + {1'b0, HYST};

   logic [PW-1:0]  ptr_q, ptr_d;
   logic [A-1:0]   acc_q  [NCH];
   logic [A-1:0]   acc_d  [NCH];
   logic [W-1:0]   hold_q [NCH];
   logic [W-1:0]   hold_d [NCH];
   logic [NCH-1:0] pend_q, pend_d;
   logic [NCH-1:0] vld_q, vld_d;
   logic [NCH-1:0] ovr_q, ovr_d;
   logic           alarm_q, alarm_d;

   logic           serv;
   logic [A-1:0]   sel_acc;
   logic [A-1:0]   upd_acc;
   logic [W-1:0]   sel_hold;
   logic [W-1:0]   alarm_avg;

   // Shared datapath: only the channel under the pointer can be updated this cycle.
   always_comb begin
      sel_acc  = acc_q[ptr_q];
      sel_hold = hold_q[ptr_q];
      serv     = pend_q[ptr_q];
      upd_acc  = sel_acc - (sel_acc >> AVG_SH) + {{AVG_SH{1'b0}}, sel_hold};
      ptr_d    = (ptr_q == PW'(NCH - 1)) ? '0 : ptr_q + 1'b1;
   end

   // Per-channel next state: preload beats service, service beats nothing, a new sample always lands in hold.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         acc_d[i]  = acc_q[i];
         hold_d[i] = hold_q[i];
      end
      pend_d = pend_q;
      vld_d  = vld_q;
      ovr_d  = clr_ovr ? '0 : ovr_q;
      for (int i = 0; i < NCH; i++) begin
         if (preload[i]) begin
            acc_d[i]  = {smpl_data[i*W +: W], {AVG_SH{1'b0}}};
            pend_d[i] = 1'b0;
            vld_d[i]  = 1'b1;
         end else begin
            if (serv && (ptr_q == PW'(i))) begin
               acc_d[i]  = upd_acc;
               pend_d[i] = 1'b0;
               vld_d[i]  = 1'b1;
            end
            if (smpl_vld[i]) begin
               hold_d[i] = smpl_data[i*W +: W];
               pend_d[i] = 1'b1;
               // A waiting sample that is not consumed right now gets overwritten.
               if (pend_q[i] && (ptr_q != PW'(i))) begin
                  ovr_d[i] = 1'b1;
               end
            end
         end
      end
   end

   // Low-level alarm with hysteresis, forced low until the monitored channel holds a valid average.
   always_comb begin
      alarm_avg = acc_q[ALARM_CH][A-1:AVG_SH];
      alarm_d   = alarm_q;
      if (!vld_q[ALARM_CH]) begin
         alarm_d = 1'b0;
      end else if (alarm_avg < LO_TH) begin
         alarm_d = 1'b1;
      end else if ({1'b0, alarm_avg} >= REL_TH) begin
         alarm_d = 1'b0;
      end
   end

   // State registers; reset wipes every pending sample and restarts the pointer at channel 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q   <= '0;
         pend_q  <= '0;
         vld_q   <= '0;
         ovr_q   <= '0;
         alarm_q <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            acc_q[i]  <= '0;
            hold_q[i] <= '0;
         end
      end else begin
         ptr_q   <= ptr_d;
         pend_q  <= pend_d;
         vld_q   <= vld_d;
         ovr_q   <= ovr_d;
         alarm_q <= alarm_d;
         for (int i = 0; i < NCH; i++) begin
            acc_q[i]  <= acc_d[i];
            hold_q[i] <= hold_d[i];
         end
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_avg
      assign avg[g*W +: W] = acc_q[g][A-1:AVG_SH];
   end

   assign avg_vld   = vld_q;
   assign ovr       = ovr_q;
   assign low_alarm = alarm_q;

endmodule

// File: tb/tb_sensor_avg_bank.sv
// Bench for sensor_avg_bank: directed scenarios then random traffic, all checked each cycle
// against an arithmetic reference model of the averaging, overrun and alarm rules.
module tb_sensor_avg_bank;

   localparam int NCH = 4;
   localparam int W   = 12;
   localparam int LO  = 'hA98;
   localparam int HY  = 'h010;

   logic          clk;
   logic          rst_n;
   logic [3:0]    smpl_vld;
   logic [47:0]   smpl_data;
   logic [3:0]    preload;
   logic          clr_ovr;
   logic [47:0]   avg;
   logic [3:0]    avg_vld;
   logic [3:0]    ovr;
   logic          low_alarm;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int m_acc  [NCH];
   int m_hold [NCH];
   bit m_pend [NCH];
   bit m_vld  [NCH];
   bit m_ovr  [NCH];
   bit m_alarm;
   int m_ptr;

   sensor_avg_bank #(
      .NCH(4), .W(12), .AVG_SH(5), .ALARM_CH(0), .LO_TH(12'hA98), .HYST(12'h010)
   ) dut (
      .clk(clk), .rst_n(rst_n), .smpl_vld(smpl_vld), .smpl_data(smpl_data),
      .preload(preload), .clr_ovr(clr_ovr), .avg(avg), .avg_vld(avg_vld),
      .ovr(ovr), .low_alarm(low_alarm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_avg(input int i);
      return (m_acc[i] / 32) % 4096;
   endfunction

   function automatic logic [47:0] put(input int ch, input int val);
      logic [47:0] r;
      r = '0;
      r[ch*12 +: 12] = 12'(val);
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_acc[i] = 0; m_hold[i] = 0; m_pend[i] = 0; m_vld[i] = 0; m_ovr[i] = 0;
      end
      m_alarm = 0;
      m_ptr   = 0;
   endtask

   // One clock edge of the behavioural rules, using the inputs that were applied.
   task automatic model_step(input logic [3:0] v, input logic [47:0] d,
                             input logic [3:0] p, input logic c);
      int a0; bit v0; bit serv; bit pend_old; int s;
      a0 = model_avg(0);
      v0 = m_vld[0];
      if (c) for (int i = 0; i < NCH; i++) m_ovr[i] = 0;
      for (int i = 0; i < NCH; i++) begin
         s        = int'(d[i*12 +: 12]);
         pend_old = m_pend[i];
         serv     = pend_old && (m_ptr == i);
         if (p[i]) begin
            m_acc[i] = s * 32; m_pend[i] = 0; m_vld[i] = 1;
         end else begin
            if (serv) begin
               m_acc[i]  = m_acc[i] - m_acc[i] / 32 + m_hold[i];
               m_pend[i] = 0;
               m_vld[i]  = 1;
            end
            if (v[i]) begin
               if (pend_old && !serv) m_ovr[i] = 1;
               m_hold[i] = s;
               m_pend[i] = 1;
            end
         end
      end
      if (!v0)                m_alarm = 0;
      else if (a0 < LO)       m_alarm = 1;
      else if (a0 >= LO + HY) m_alarm = 0;
      m_ptr = (m_ptr + 1) % NCH;
   endtask

   task automatic check_all();
      logic [3:0] mv, mo;
      for (int i = 0; i < NCH; i++) begin
         chk($sformatf("avg%0d", i), 32'(avg[i*12 +: 12]), 32'(model_avg(i)));
         mv[i] = m_vld[i];
         mo[i] = m_ovr[i];
      end
      chk("avg_vld", 32'(avg_vld), 32'(mv));
      chk("ovr", 32'(ovr), 32'(mo));
      chk("low_alarm", 32'(low_alarm), 32'(m_alarm));
   endtask

   task automatic cyc(input logic [3:0] v, input logic [47:0] d, input logic [3:0] p, input logic c);
      smpl_vld = v; smpl_data = d; preload = p; clr_ovr = c;
      @(posedge clk);
      model_step(v, d, p, c);
      #1;
      smpl_vld = '0; smpl_data = '0; preload = '0; clr_ovr = 1'b0;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc('0, '0, '0, 1'b0);
   endtask

   task automatic wait_ptr(input int target);
      for (int k = 0; k < NCH && m_ptr != target; k++) idle(1);
   endtask

   // Called just after an edge: pulses reset between edges and checks the asynchronous clear.
   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_avg", avg[31:0], 32'h0);
      chk("rst_avg_hi", 32'(avg[47:32]), 32'h0);
      chk("rst_vld", 32'(avg_vld), 32'h0);
      chk("rst_ovr", 32'(ovr), 32'h0);
      chk("rst_alarm", 32'(low_alarm), 32'h0);
      model_reset();
      #2 rst_n = 1'b1;
   endtask

   initial begin
      int prev, a;
      logic [63:0] rnd;
      logic [3:0]  rv, rp;
      logic [47:0] rd;

      rst_n = 1'b0; smpl_vld = '0; smpl_data = '0; preload = '0; clr_ovr = 1'b0;
      model_reset();
      #2;
      chk("init_avg", avg[31:0], 32'h0);
      chk("init_vld", 32'(avg_vld), 32'h0);
      chk("init_ovr", 32'(ovr), 32'h0);
      chk("init_alarm", 32'(low_alarm), 32'h0);
      #10 rst_n = 1'b1;

      // Preload channel 1
      cyc('0, put(1, 'h800), 4'b0010, 1'b0);
      chk("pre_avg1", 32'(avg[23:12]), 32'h800);
      chk("pre_vld", 32'(avg_vld), 32'h2);

      // Constant 0x400 on ch0 every 8 cycles from reset: monotone rise to 0x400
      async_reset();
      prev = 0;
      a    = 0;
      for (int k = 0; k < 300; k++) begin
         cyc(4'b0001, put(0, 'h400), '0, 1'b0);
         idle(7);
         a = int'(avg[11:0]);
         if (k == 0) chk("first_upd", 32'(a), 32'h020);
         chk("mono", 32'(a >= prev && a <= 'h400), 32'h1);
         prev = a;
      end
      chk("converged", 32'(a), 32'h400);

      // Overrun on ch2: two strobes while not serviced, second sample kept
      wait_ptr(3);
      cyc(4'b0100, put(2, 'h123), '0, 1'b0);
      cyc(4'b0100, put(2, 'h456), '0, 1'b0);
      chk("ovr2_set", 32'(ovr[2]), 32'h1);
      idle(4);
      chk("ovr2_2nd", 32'(avg[35:24]), 32'h022);
      cyc('0, '0, '0, 1'b1);
      chk("ovr2_clr", 32'(ovr[2]), 32'h0);

      // New overrun in the same cycle as clr_ovr wins
      wait_ptr(3);
      cyc(4'b0100, put(2, 'h300), '0, 1'b0);
      cyc(4'b0100, put(2, 'h310), '0, 1'b1);
      chk("ovr_wins_clr", 32'(ovr[2]), 32'h1);
      cyc('0, '0, '0, 1'b1);
      idle(4);

      // Strobe on the channel being serviced: re-pends, no overrun
      wait_ptr(1);
      cyc(4'b0100, put(2, 'h200), '0, 1'b0);
      cyc(4'b0100, put(2, 'h210), '0, 1'b0);
      chk("svc_no_ovr", 32'(ovr[2]), 32'h0);
      idle(4);

      // Alarm thresholds and hysteresis on ch0
      cyc('0, put(0, 'hB00), 4'b0001, 1'b0); idle(1);
      chk("alm_off", 32'(low_alarm), 32'h0);
      cyc('0, put(0, 'hA98), 4'b0001, 1'b0); idle(1);
      chk("alm_at_th", 32'(low_alarm), 32'h0);
      cyc('0, put(0, 'hA90), 4'b0001, 1'b0); idle(1);
      chk("alm_on", 32'(low_alarm), 32'h1);
      for (int k = 0; k < 4; k++) begin
         cyc(4'b0001, put(0, 'hA90), '0, 1'b0);
         idle(3);
         chk("alm_hold_avg", 32'(avg[11:0]), 32'hA90);
         chk("alm_hold", 32'(low_alarm), 32'h1);
      end
      idle(4);
      cyc('0, put(0, 'hAA0), 4'b0001, 1'b0); idle(1);
      chk("alm_hyst_aa0", 32'(low_alarm), 32'h1);
      cyc('0, put(0, 'hAA7), 4'b0001, 1'b0); idle(1);
      chk("alm_hyst_aa7", 32'(low_alarm), 32'h1);
      cyc('0, put(0, 'hAA8), 4'b0001, 1'b0); idle(1);
      chk("alm_release", 32'(low_alarm), 32'h0);
      cyc('0, put(0, 'hA97), 4'b0001, 1'b0); idle(1);
      chk("alm_below", 32'(low_alarm), 32'h1);

      // All channels strobed at once: drained in ptr order, no overrun
      cyc('0, '0, '0, 1'b1);
      idle(4);
      cyc(4'hF, put(0, 'h111) | put(1, 'h222) | put(2, 'h333) | put(3, 'h444), '0, 1'b0);
      idle(4);
      chk("all4_ovr", 32'(ovr), 32'h0);
      chk("all4_vld", 32'(avg_vld), 32'hF);

      // Reset while three samples pend: nothing updates afterwards
      wait_ptr(3);
      cyc(4'b0111, put(0, 'h7FF) | put(1, 'h6FF) | put(2, 'h5FF), '0, 1'b0);
      async_reset();
      idle(8);
      chk("post_rst_avg", avg[31:0], 32'h0);
      chk("post_rst_vld", 32'(avg_vld), 32'h0);

      // Random traffic against the model
      for (int k = 0; k < 600; k++) begin
         rnd = {$urandom, $urandom};
         rd  = rnd[47:0];
         if ($urandom_range(0, 1) == 0) rd[11:0] = 12'(12'hA80 + $urandom_range(0, 63));
         rv = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
         rp = ($urandom_range(0, 15) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
         cyc(rv, rd, rp, $urandom_range(0, 31) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sensor_avg_bank.md
SENSOR_AVG_BANK -- requirements
Module: sensor_avg_bank

Interface
REQ-001 Parameter NCH, default 4: number of sensor channels, 1..16.
REQ-002 Parameter W, default 12: sample and average width in bits.
REQ-003 Parameter AVG_SH, default 5: exponential-average shift; accumulator width A = W+AVG_SH.
REQ-004 Parameter ALARM_CH, default 0: channel index monitored by the low-level alarm.
REQ-005 Parameter LO_TH, default 12'hA98: alarm assert threshold, W bits.
REQ-006 Parameter HYST, default 12'h010: alarm release hysteresis, W bits.
REQ-007 clk  input  1  clock; all state updates on rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 smpl_vld  input  NCH  per-channel new-sample strobe, one cycle per sample.
REQ-010 smpl_data  input  NCH*W  per-channel sample; channel i occupies bits [i*W +: W].
REQ-011 preload  input  NCH  per-channel reinitialise: load the average directly from smpl_data.
REQ-012 clr_ovr  input  1  clears all overrun flags.
REQ-013 avg  output  NCH*W  per-channel average, acc_i[A-1:AVG_SH], packed as smpl_data.
REQ-014 avg_vld  output  NCH  channel i has been updated or preloaded at least once since reset.
REQ-015 ovr  output  NCH  sticky: a sample was lost on channel i.
REQ-016 low_alarm  output  1  registered alarm on the channel ALARM_CH average.

Function
REQ-017 Each channel has a W-bit hold register, a pending bit and an A-bit accumulator acc_i.
REQ-018 On smpl_vld[i] without preload[i]: hold_i <= sample; pending_i <= 1.
- If pending_i was already 1 and is not being serviced in that cycle: ovr[i] <= 1 and the new sample replaces the old one.
REQ-019 A sequencer pointer ptr (0..NCH-1) advances by 1 every cycle and wraps from NCH-1 to 0 unconditionally.
REQ-020 When pending_ptr = 1, the block SHALL update the channel:
- acc_ptr <= acc_ptr - (acc_ptr >> AVG_SH) + hold_ptr (unsigned, A bits, no saturation; the result never exceeds (2^W-1)*2^AVG_SH).
- pending_ptr <= 0; avg_vld[ptr] <= 1.
REQ-021 One arithmetic datapath SHALL be shared across all channels; at most one accumulator updates per cycle.
REQ-022 A smpl_vld on the channel being serviced in the same cycle SHALL set pending again with the new sample and SHALL NOT flag an overrun.
REQ-023 Latency from the smpl_vld edge to the avg change SHALL be 1..NCH cycles, deterministic from ptr.
REQ-024 On preload[i]: acc_i <= {sample_i, AVG_SH'b0}; pending_i <= 0; avg_vld[i] <= 1.
- Preload has priority over smpl_vld and over servicing in the same cycle.
REQ-025 On clr_ovr: ovr <= 0. A simultaneous new overrun on a channel SHALL win (that bit is set).
REQ-026 low_alarm is evaluated only while avg_vld[ALARM_CH] = 1, and SHALL be 0 otherwise.
- Sets to 1 when avg < LO_TH.
- Clears to 0 when avg >= LO_TH+HYST (computed W+1 bits wide, no wrap).
- Otherwise it holds its value.
REQ-027 low_alarm SHALL be registered, lagging the avg change by 1 cycle.

Reset
REQ-028 While rst_n = 0: acc, hold, pending, ptr, avg_vld, ovr and low_alarm SHALL all be 0, immediately and independent of clk.
REQ-029 Reset asserted mid-operation SHALL discard all pending samples; after release, ptr restarts at 0.

Verification
REQ-030 Verification SHALL cover the following directed scenarios:
- Defaults, preload ch1 = 0x800 -> avg[1] = 0x800 the next cycle; avg_vld = 4'b0010.
- Constant sample 0x400 on ch0 every 8 cycles from reset -> avg[0] converges monotonically to 0x400 and never overshoots; first update gives acc0 = 0x400 (avg = 0x020).
- Two smpl_vld on ch2 within 1 cycle, with ptr not at 2 -> ovr[2] = 1 and the second sample is used; clr_ovr -> ovr[2] = 0.
- Preload ch0 = 0xA90, then hold samples at 0xA90 -> low_alarm = 1; preload 0xAA0 -> low_alarm stays 1 (below 0xAA8); preload 0xAA8 -> low_alarm = 0.
- All 4 channels strobed in the same cycle -> each avg updates exactly once within 4 cycles, in ptr order, with no overrun.
- rst_n pulsed low while 3 samples are pending -> all outputs 0 asynchronously, and no update occurs after release.
